// File: rtl/rtc_edit_pkg.sv
// Shared definitions for the RTC field editor.
// Holds the mode encodings, the editor state type, the default auto-repeat
// timing, and field_limits(). field_limits() returns the legal {min, max}
// range of each field in each mode.
package rtc_edit_pkg;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_DATE  = 2'b01;
  localparam logic [1:0] MODE_TIME  = 2'b10;
  localparam logic [1:0] MODE_TIMER = 2'b11;

  localparam int DEF_REPEAT_DELAY = 25_000_000;
  localparam int DEF_REPEAT_RATE  = 5_000_000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EDIT   = 2'd2,
    COMMIT = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
  } limits_t;

  // Date fields: 0 day, 1 month, 2 year. Time/timer fields: 0 hour, 1 min, 2 sec.
  // Fields or modes that have no calendar meaning fall back to 0..99.
  function automatic limits_t field_limits(input logic [1:0] mode, input int idx);
    limits_t l;
    l.lo = 8'd0;
    l.hi = 8'd99;
    if (mode == MODE_DATE) begin
      case (idx)
        0:       begin l.lo = 8'd1; l.hi = 8'd31; end
        1:       begin l.lo = 8'd1; l.hi = 8'd12; end
        default: begin l.lo = 8'd0; l.hi = 8'd99; end
      endcase
    end else if (mode == MODE_TIME || mode == MODE_TIMER) begin
      case (idx)
        0:       begin l.lo = 8'd0; l.hi = 8'd23; end
        1, 2:    begin l.lo = 8'd0; l.hi = 8'd59; end
        default: begin l.lo = 8'd0; l.hi = 8'd99; end
      endcase
    end
    return l;
  endfunction

endpackage

// File: rtl/rtc_field_editor_if.sv
// Bus between the button/switch front end (master) and the field editor (slave).
// Master drives mode, the debounced buttons and the live RTC snapshot.
// Slave returns the cursor, the field under the cursor, all fields, the edit
// flag and the commit strobe with its mode.
interface rtc_field_editor_if #(
  parameter int NUM_FIELDS = 3,
  parameter int VAL_W      = 7,
  parameter int SEL_W      = $clog2(NUM_FIELDS)
);
  logic [1:0]                  programacion;
  logic                        incremento;
  logic                        decremento;
  logic                        derecha;
  logic                        izquierda;
  logic [NUM_FIELDS*VAL_W-1:0] load_data;
  logic [SEL_W-1:0]            seleccion;
  logic [VAL_W-1:0]            cuenta;
  logic [NUM_FIELDS*VAL_W-1:0] fields_out;
  logic                        editing;
  logic                        commit;
  logic [1:0]                  commit_mode;

  modport master (
    output programacion, incremento, decremento, derecha, izquierda, load_data,
    input  seleccion, cuenta, fields_out, editing, commit, commit_mode
  );

  modport slave (
    input  programacion, incremento, decremento, derecha, izquierda, load_data,
    output seleccion, cuenta, fields_out, editing, commit, commit_mode
  );
endinterface

// File: rtl/button_repeat.sv
// Turns a debounced button level into single-cycle step pulses.
// A step is produced on the rising edge. While the button stays held, a step
// is also produced REPEAT_DELAY cycles after the edge, then every REPEAT_RATE
// cycles. REPEAT_DELAY = 0 gives edge-only behaviour.
// Ports: clk, reset (async, active-high), btn (level), enable (steps allowed),
//        step (1-cycle pulse).
module button_repeat
  import rtc_edit_pkg::*;
#(
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic enable,
  output logic step
);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);

  logic             btn_q, btn_d;
  logic             rep_q, rep_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise, tick;

  // btn_q tracks the level even while disabled, so a button already held when
  // enable rises never looks like a fresh press.
  always_comb begin
    btn_d = btn;
    rise  = btn & ~btn_q;
    tick  = 1'b0;
    cnt_d = cnt_q;
    rep_d = rep_q;
    if (!btn || !enable) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (REPEAT_DELAY > 0) begin
      // cnt_q = 0 means idle; otherwise it counts cycles since the edge or the last tick.
      if (rise) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != '0) begin
        if ((!rep_q && cnt_q == CNT_W'(REPEAT_DELAY)) ||
            ( rep_q && cnt_q == CNT_W'(REPEAT_RATE))) begin
          tick  = 1'b1;
          cnt_d = CNT_W'(1);
          rep_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
    step = enable & (rise | tick);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q <= 1'b0;
      rep_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      btn_q <= btn_d;
      rep_q <= rep_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/rtc_field_editor.sv
// RTC field editor.
// Selecting a non-run mode loads a snapshot of the live RTC values into
// per-field registers. Values outside the field's range are replaced by the
// field's minimum. The buttons then edit the field under the cursor with wrap
// at the limits and auto-repeat. Leaving the mode emits a one-cycle commit
// with the mode being committed.
// Ports: clk, reset (async, active-high), bus (rtc_field_editor_if.slave).
module rtc_field_editor
  import rtc_edit_pkg::*;
#(
  parameter int NUM_FIELDS   = 3,
  parameter int VAL_W        = 7,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int SEL_W        = $clog2(NUM_FIELDS)
) (
  input logic           clk,
  input logic           reset,
  rtc_field_editor_if.slave bus
);
  state_e           state_q, state_d;
  logic [1:0]       cur_mode_q, cur_mode_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [VAL_W-1:0] fields_q [NUM_FIELDS];
  logic [VAL_W-1:0] fields_d [NUM_FIELDS];
  logic             edit_en;
  logic             inc_step, dec_step, right_step, left_step;

  assign edit_en = (state_q == EDIT);

  button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_inc (
    .clk(clk), .reset(reset), .btn(bus.incremento), .enable(edit_en), .step(inc_step));
  button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dec (
    .clk(clk), .reset(reset), .btn(bus.decremento), .enable(edit_en), .step(dec_step));
  button_repeat #(.REPEAT_DELAY(0), .REPEAT_RATE(0)) u_right (
    .clk(clk), .reset(reset), .btn(bus.derecha), .enable(edit_en), .step(right_step));
  button_repeat #(.REPEAT_DELAY(0), .REPEAT_RATE(0)) u_left (
    .clk(clk), .reset(reset), .btn(bus.izquierda), .enable(edit_en), .step(left_step));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.programacion != MODE_RUN) state_d = LOAD;
      LOAD:    state_d = EDIT;
      EDIT:    if (bus.programacion != cur_mode_q) state_d = COMMIT;
      COMMIT:  state_d = (bus.programacion == MODE_RUN) ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.editing     = (state_q == EDIT);
    bus.commit      = (state_q == COMMIT);
    bus.commit_mode = (state_q == COMMIT) ? cur_mode_q : MODE_RUN;
  end

  // Field, cursor and mode datapath
  always_comb begin
    limits_t          lim;
    logic [VAL_W-1:0] lo, hi, cur, ld_v;
    fields_d   = fields_q;
    sel_d      = sel_q;
    cur_mode_d = cur_mode_q;
    lim        = field_limits(cur_mode_q, int'(sel_q));
    lo         = VAL_W'(lim.lo);
    hi         = VAL_W'(lim.hi);
    cur        = fields_q[sel_q];
    ld_v       = '0;
    if (state_q == LOAD) begin
      cur_mode_d = bus.programacion;
      sel_d      = '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        lim  = field_limits(bus.programacion, i);
        ld_v = bus.load_data[i*VAL_W +: VAL_W];
        if (ld_v < VAL_W'(lim.lo) || ld_v > VAL_W'(lim.hi)) fields_d[i] = VAL_W'(lim.lo);
        else                                                fields_d[i] = ld_v;
      end
    end else if (state_q == EDIT) begin
      // Step uses the pre-move cursor, so a simultaneous move edits the old field.
      if (inc_step && !dec_step)
        fields_d[sel_q] = (cur >= hi) ? lo : cur + VAL_W'(1);
      else if (dec_step && !inc_step)
        fields_d[sel_q] = (cur <= lo) ? hi : cur - VAL_W'(1);
      if (right_step && !left_step)
        sel_d = (sel_q == SEL_W'(NUM_FIELDS - 1)) ? '0 : sel_q + SEL_W'(1);
      else if (left_step && !right_step)
        sel_d = (sel_q == '0) ? SEL_W'(NUM_FIELDS - 1) : sel_q - SEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_mode_q <= MODE_RUN;
      sel_q      <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) fields_q[i] <= '0;
    end else begin
      cur_mode_q <= cur_mode_d;
      sel_q      <= sel_d;
      for (int i = 0; i < NUM_FIELDS; i++) fields_q[i] <= fields_d[i];
    end
  end

  always_comb begin
    bus.fields_out = '0;
    for (int i = 0; i < NUM_FIELDS; i++) bus.fields_out[i*VAL_W +: VAL_W] = fields_q[i];
  end

  assign bus.seleccion = sel_q;
  assign bus.cuenta    = fields_q[sel_q];
endmodule
